// File: rtl/gift_sbox_layer.sv
// GIFT S-box layer: substitutes every nibble of a GIFT-64/128 state, forward or inverse,
// LANES nibbles per clock, with a valid/ready front and back end.
module gift_sbox_layer #(
  parameter int NIBBLES = 16,
  parameter int LANES   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_data,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_data,
  output logic                 busy
);

  localparam int W     = 4 * NIBBLES;
  localparam int STEPS = (LANES > 0) ? (NIBBLES / LANES) : 1;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (LANES < 1 || LANES > NIBBLES || (NIBBLES % LANES) != 0) begin : g_bad_lanes
    $error("gift_sbox_layer: LANES must divide NIBBLES and lie in 1..NIBBLES");
  end

  logic [1:0]    fsm_q, fsm_d;
  logic [W-1:0]  state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic          mode_q, mode_d;
  logic          accept;
  int            nib_idx;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'h1;
      4'h1: r = 4'hA;
      4'h2: r = 4'h4;
      4'h3: r = 4'hC;
      4'h4: r = 4'h6;
      4'h5: r = 4'hF;
      4'h6: r = 4'h3;
      4'h7: r = 4'h9;
      4'h8: r = 4'h2;
      4'h9: r = 4'hD;
      4'hA: r = 4'hB;
      4'hB: r = 4'h7;
      4'hC: r = 4'h5;
      4'hD: r = 4'h0;
      4'hE: r = 4'h8;
      default: r = 4'hE;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hD;
      4'h1: r = 4'h0;
      4'h2: r = 4'h8;
      4'h3: r = 4'h6;
      4'h4: r = 4'h2;
      4'h5: r = 4'hC;
      4'h6: r = 4'h4;
      4'h7: r = 4'hB;
      4'h8: r = 4'hE;
      4'h9: r = 4'h7;
      4'hA: r = 4'h1;
      4'hB: r = 4'hA;
      4'hC: r = 4'h3;
      4'hD: r = 4'h9;
      4'hE: r = 4'hF;
      default: r = 4'h5;
    endcase
    return r;
  endfunction

  // Handshake: a transfer happens on a rising edge where valid && ready; valid and its
  // payload hold until that edge, and ready never depends on the same side's valid.
  assign in_ready  = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready);
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_BUSY);
  assign out_data  = state_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    step_d  = step_q;
    mode_d  = mode_q;
    nib_idx = 0;
    case (fsm_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = in_data;
          mode_d  = in_mode;
          step_d  = '0;
          fsm_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Lowest nibbles first; untouched nibbles keep their input value until their step.
        for (int l = 0; l < LANES; l++) begin
          nib_idx = int'(step_q) * LANES + l;
          state_d[4*nib_idx +: 4] = mode_q ? sbox_inv(state_q[4*nib_idx +: 4])
                                           : sbox_fwd(state_q[4*nib_idx +: 4]);
        end
        if (step_q == LAST_STEP) begin
          fsm_d = ST_DONE;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_d = ST_IDLE;
          if (accept) begin
            state_d = in_data;
            mode_d  = in_mode;
            step_d  = '0;
            fsm_d   = ST_BUSY;
          end
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      step_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
    end
  end

endmodule
